// File: rtl/psw_debounce_pkg.sv
// Shared constants for the push-button conditioner and a helper that sizes the
// sample prescaler counter.
package psw_debounce_pkg;

  localparam int PSW_N           = 20;
  localparam int PSW_DIV_DEFAULT = 50000;
  localparam int PSW_K_DEFAULT   = 4;
  localparam int PSW_DIV_SIM     = 4;

  // Counter width for a 0..div-1 count; a 1-bit floor keeps tiny dividers legal.
  function automatic int psw_cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/psw_debounce_bit.sv
// One switch channel: two-flop synchroniser, tick-sampled history, debounced
// level and single-cycle press/release pulses.
module psw_debounce_bit
  import psw_debounce_pkg::*;
#(
  parameter int K = PSW_K_DEFAULT
) (
  input  logic sys_clock,
  input  logic reset,
  input  logic sample_tick,
  input  logic psw_raw_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  logic         s1_q, s1_d;
  logic         s2_q, s2_d;
  logic [K-1:0] hist_q, hist_d;
  logic         pressed_q, pressed_d;
  logic         press_pulse_q, press_pulse_d;
  logic         release_pulse_q, release_pulse_d;

  always_comb begin
    s1_d            = ~psw_raw_n;
    s2_d            = s1_q;
    hist_d          = hist_q;
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    // State is judged against the history including the sample taken this tick.
    if (sample_tick) begin
      hist_d = {hist_q[K-2:0], s2_q};
      if (!pressed_q && (&hist_d)) begin
        pressed_d     = 1'b1;
        press_pulse_d = 1'b1;
      end else if (pressed_q && !(|hist_d)) begin
        pressed_d       = 1'b0;
        release_pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      s1_q            <= 1'b0;
      s2_q            <= 1'b0;
      hist_q          <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      hist_q          <= hist_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;

endmodule

// File: rtl/psw_debounce.sv
// Push-button input conditioner: shared sample prescaler feeding N independent
// debounce channels.
module psw_debounce
  import psw_debounce_pkg::*;
#(
  parameter int N   = PSW_N,
  parameter int DIV = PSW_DIV_DEFAULT,
  parameter int K   = PSW_K_DEFAULT
) (
  input  logic         sys_clock,
  input  logic         reset,
  input  logic [N-1:0] psw_raw,
  output logic [N-1:0] pressed,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic         any_pressed,
  output logic         sample_tick
);

  localparam int            CW      = psw_cnt_width(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CNT_MAX) cnt_d = '0;
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Decoded straight from the counter so it is low throughout reset.
  assign sample_tick = (cnt_q == CNT_MAX);
  assign any_pressed = |pressed;

  for (genvar i = 0; i < N; i++) begin : g_bit
    psw_debounce_bit #(.K(K)) u_bit (
      .sys_clock     (sys_clock),
      .reset         (reset),
      .sample_tick   (sample_tick),
      .psw_raw_n     (psw_raw[i]),
      .pressed       (pressed[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule

// File: tb/tb_psw_debounce.sv
// Bench for psw_debounce with DIV=4, K=3, N=20: pulse events are predicted with
// a cycle window and matched in order as the outputs report them.
module tb_psw_debounce;
  import psw_debounce_pkg::*;

  localparam int N   = PSW_N;
  localparam int DIV = PSW_DIV_SIM;
  localparam int K   = 3;
  localparam int W   = 40;

  logic         clk;
  logic         reset;
  logic [N-1:0] psw_raw;
  logic [N-1:0] pressed, press_pulse, release_pulse;
  logic         any_pressed, sample_tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulse_cyc [N];
  logic [W-1:0] exp_q[$];

  psw_debounce #(.N(N), .DIV(DIV), .K(K)) dut (
    .sys_clock     (clk),
    .reset         (reset),
    .psw_raw       (psw_raw),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .any_pressed   (any_pressed),
    .sample_tick   (sample_tick)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // event word: {pad, kind(1=press,2=release), bit, earliest cycle, latest cycle}
  task automatic push_ev(input logic [1:0] kind, input int idx, input int lo, input int hi);
    exp_q.push_back({1'b0, kind, 5'(idx), 16'(lo), 16'(hi)});
  endtask

  task automatic match_ev(input logic [1:0] kind, input int idx);
    logic [W-1:0] got, e;
    got = {1'b0, kind, 5'(idx), 32'd0};
    if (exp_q.size() == 0) begin
      check("spurious_pulse", got, '0);
    end else begin
      e = exp_q.pop_front();
      check("pulse_id", W'(got[38:32]), W'(e[38:32]));
      check("pulse_window", W'((cyc >= int'(e[31:16])) && (cyc <= int'(e[15:0]))), W'(1));
    end
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (press_pulse[i]) begin
        pulse_cyc[i] = cyc;
        check("press_level", W'(pressed[i]), W'(1));
        match_ev(2'd1, i);
      end
      if (release_pulse[i]) begin
        check("release_level", W'(pressed[i]), W'(0));
        match_ev(2'd2, i);
      end
    end
  end

  // driver helpers: inputs change 1 time unit after a rising edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pressed"}, W'(pressed), '0);
    check({tag, "_ppulse"}, W'(press_pulse), '0);
    check({tag, "_rpulse"}, W'(release_pulse), '0);
    check({tag, "_any"}, W'(any_pressed), '0);
    check({tag, "_tick"}, W'(sample_tick), '0);
  endtask

  initial begin
    int e, r, n;
    logic lvl;
    for (int i = 0; i < N; i++) pulse_cyc[i] = -1;
    reset   = 1'b0;
    psw_raw = '1;
    step(3);
    check_all_zero("reset");

    // tick cadence from reset release
    reset = 1'b1;
    r = cyc;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      check("tick_phase", W'(sample_tick), W'((j % DIV) == DIV - 1));
    end
    step(1);

    // clean press and release on bit 0
    e = cyc;
    psw_raw[0] = 1'b0;
    push_ev(2'd1, 0, e + 11, e + 14);
    step(16);
    check("press_level0", W'(pressed), W'(20'h00001));
    check("press_any", W'(any_pressed), W'(1));
    e = cyc;
    psw_raw[0] = 1'b1;
    push_ev(2'd2, 0, e + 11, e + 14);
    step(16);
    check("release_level0", W'(pressed), '0);
    check("release_any", W'(any_pressed), W'(0));

    // bounce on bit 5: toggle every 3 cycles, then hold pressed
    lvl = 1'b0;
    for (int j = 0; j < 13; j++) begin
      psw_raw[5] = lvl;
      lvl = ~lvl;
      step(3);
    end
    check("bounce_quiet", W'(pressed), '0);
    e = cyc;
    psw_raw[5] = 1'b0;
    push_ev(2'd1, 5, e + 1, e + 14);
    step(16);
    check("bounce_level", W'(pressed), W'(20'h00020));
    e = cyc;
    psw_raw[5] = 1'b1;
    push_ev(2'd2, 5, e + 11, e + 14);
    step(16);

    // 8-cycle glitches on bit 7 at every tick phase
    for (int off = 0; off < DIV; off++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!sample_tick && n < 2 * DIV);
      check("tick_found", W'(sample_tick), W'(1));
      step(1 + off);
      psw_raw[7] = 1'b0;
      step(8);
      psw_raw[7] = 1'b1;
      step(16);
      check("glitch_level", W'(pressed), '0);
    end

    // simultaneous presses on bits 0 and 19
    e = cyc;
    psw_raw[0]  = 1'b0;
    psw_raw[19] = 1'b0;
    push_ev(2'd1, 0, e + 11, e + 14);
    push_ev(2'd1, 19, e + 11, e + 14);
    step(16);
    check("simul_level", W'(pressed), W'(20'h80001));
    check("simul_cycle", W'(pulse_cyc[19]), W'(pulse_cyc[0]));

    // reset while both are held: outputs drop at once, then re-press
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    step(3);
    reset = 1'b1;
    r = cyc;
    push_ev(2'd1, 0, r + 11, r + 13);
    push_ev(2'd1, 19, r + 11, r + 13);
    step(16);
    check("rearm_level", W'(pressed), W'(20'h80001));
    e = cyc;
    psw_raw[0]  = 1'b1;
    psw_raw[19] = 1'b1;
    push_ev(2'd2, 0, e + 11, e + 14);
    push_ev(2'd2, 19, e + 11, e + 14);
    step(16);
    check("final_level", W'(pressed), '0);
    check("pending_events", W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psw_debounce.md
# psw_debounce

Input conditioner for the board's push-button switches (psw_a0 … psw_d4). It synchronises the raw active-low switch lines to sys_clock and debounces them with a shared sampling prescaler. For each switch it produces:
- a clean active-high level;
- a one-cycle press pulse;
- a one-cycle release pulse.

It sits between the top-level switch pins and the blocks that consume user input, such as counter enables and single-step controls.

## Interface
Parameters:
- N, 20: number of switches handled.
- DIV, 50000: sys_clock cycles per sample tick (≥2).
- K, 4: consecutive equal samples required to change state (2..8).

Ports:
- sys_clock  in  1  system clock; the only clock, all state on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- psw_raw  in  N  raw switch lines; active-low (0 = pressed); asynchronous to sys_clock.
- pressed  out  N  debounced level; 1 = pressed.
- press_pulse  out  N  1 for exactly one cycle when pressed[i] rises.
- release_pulse  out  N  1 for exactly one cycle when pressed[i] falls.
- any_pressed  out  1  OR of pressed.
- sample_tick  out  1  prescaler tick; exported for test and for other samplers.

## Operation
- Synchroniser per bit:
  - two flops on ~psw_raw[i] (inverted to active-high);
  - s2[i] is the synchronised value;
  - reset value 0.
- Prescaler:
  - shared counter 0..DIV-1, ceil(log2 DIV) bits;
  - increments every cycle and wraps to 0 after DIV-1;
  - sample_tick = (count == DIV-1), combinational from the counter.
- History per bit:
  - K-bit shift register, updated only on cycles with sample_tick = 1;
  - new history = {hist[K-2:0], s2[i]}.
- State per bit (pressed[i]), evaluated on tick cycles against the new history:
  - 0 → 1 when the new history is all ones; press_pulse[i] = 1 on the same edge.
  - 1 → 0 when the new history is all zeros; release_pulse[i] = 1 on the same edge.
  - Otherwise state holds.
- Pulses are registered and cleared on the next edge, so no pulse is ever longer than one cycle.
- Bits are fully independent. Simultaneous presses on several bits produce simultaneous pulses.
- Mixed history (bouncing) never changes state.

## Timing
- Reset values (asynchronous; all outputs valid during reset):
  - count = 0, s1 = s2 = 0, history = 0;
  - pressed = 0, press_pulse = 0, release_pulse = 0;
  - any_pressed = 0, sample_tick = 0.
- Press latency:
  - psw_raw[i] falls and is captured by s1 at edge t;
  - pressed[i] and press_pulse[i] rise at an edge in [t+2+DIV·(K-1), t+1+DIV·K].
- Release latency: symmetric to press latency.
- Glitch rejection: a raw pulse shorter than DIV·(K-1)+1 cycles never changes pressed.
- First tick after reset: at the edge ending cycle DIV-1.
- Reset mid-debounce: the history is lost. A switch held through reset re-asserts pressed after the full press latency counted from reset release, and generates a press_pulse.
- Prescaler wrap is seamless; tick period is exactly DIV cycles.

## Structure
- The shared constants package holds:
  - PSW_N = 20;
  - PSW_DIV_DEFAULT = 50000;
  - PSW_K_DEFAULT = 4;
  - PSW_DIV_SIM = 4 (bench value).
- Sub-module psw_debounce_bit handles one switch: synchroniser, history, state and pulses, with sample_tick as an input.
- The top level holds the prescaler and a generate loop over N instances.
- Target size is about 150 lines of RTL in total.

## Test plan
All scenarios use DIV=4, K=3, N=20.
- Reset and tick:
  - hold reset=0 with psw_raw = all ones → every output 0;
  - release reset → sample_tick high every 4th cycle, first at cycle 3.
- Clean press:
  - drive psw_raw[0]=0 at edge t → pressed[0] rises in [t+10, t+13];
  - press_pulse[0] is high for exactly 1 cycle;
  - any_pressed = 1; all other outputs stay 0.
- Clean release:
  - with pressed[0]=1, drive psw_raw[0]=1 → pressed[0] falls after the same latency bound;
  - release_pulse[0] is high for 1 cycle.
- Bounce:
  - toggle psw_raw[5] every 3 cycles for 40 cycles, then hold 0;
  - → no output changes during the bounce;
  - exactly one press_pulse[5] within 13 cycles after the hold begins.
- Glitch:
  - drive psw_raw[7]=0 for 8 cycles at every phase offset 0..3 → pressed[7] never rises.
- Simultaneous and reset mid-operation:
  - press bits 0 and 19 on the same cycle → identical pulse cycle on both;
  - assert reset mid-debounce while held → outputs 0 immediately;
  - after reset release → pressed re-asserts 10..13 cycles later with one press_pulse.
